// File: rtl/concat_pkg.sv
// Shared frame geometry for the three-channel concatenator and its downstream packer.
// Frame lengths live here only so both sides stay in step.
package concat_pkg;
  localparam int LENGTH1     = 144;
  localparam int LENGTH2     = 12;
  localparam int LENGTH3     = 132;
  localparam int FRAME_BYTES = LENGTH1 + LENGTH2 + LENGTH3;

  typedef enum logic {ST_DATA = 1'b0, ST_TRAILER = 1'b1} state_e;

  // Trailer word: sequence number in the upper half, byte checksum in the lower half.
  localparam int TRL_W        = 32;
  localparam int TRL_FIELD_W  = 16;
  localparam int TRL_CSUM_LSB = 0;
  localparam int TRL_SEQ_LSB  = 16;

  function automatic logic [TRL_W-1:0] trailer_word(input logic [TRL_FIELD_W-1:0] seq,
                                                    input logic [TRL_FIELD_W-1:0] csum);
    logic [TRL_W-1:0] w;
    w = '0;
    w[TRL_SEQ_LSB  +: TRL_FIELD_W] = seq;
    w[TRL_CSUM_LSB +: TRL_FIELD_W] = csum;
    return w;
  endfunction
endpackage

// File: rtl/concat_out_reg.sv
// One-entry output register: a word plus first/last flags held until the consumer takes it.
module concat_out_reg #(
  parameter int W = 32
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         first_i,
  input  logic         last_i,
  input  logic         ready_i,
  output logic         free_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         first_o,
  output logic         last_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  logic         first_q, last_q;

  // Free when empty or when the current word leaves this cycle.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign first_o = first_q;
  assign last_o  = last_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      first_q <= first_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/concat_frame_packer.sv
// Packs the concatenator byte stream little-endian into wide words, flags frame
// boundaries and optionally appends a {seq, checksum} trailer word per frame.
module concat_frame_packer #(
  parameter int IN_WIDTH       = 8,
  parameter int OUT_WIDTH      = 32,
  parameter int FRAME_BYTES    = concat_pkg::FRAME_BYTES,
  parameter int APPEND_TRAILER = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [IN_WIDTH-1:0]  i_in_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [OUT_WIDTH-1:0] o_out_data,
  output logic                 o_out_valid,
  output logic                 o_out_first,
  output logic                 o_out_last,
  input  logic                 i_out_ready,
  output logic [15:0]          o_frame_count
);
  import concat_pkg::*;

  localparam int LANES = OUT_WIDTH / IN_WIDTH;
  localparam int WORDS = FRAME_BYTES / LANES;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);

  state_e               state_q;
  logic [LW-1:0]        lane_q;
  logic [WW-1:0]        word_idx_q;
  logic [15:0]          csum_q, csum_d;
  logic [15:0]          seq_q;
  logic [15:0]          frame_cnt_q;
  logic [OUT_WIDTH-1:0] asm_q, word_d;

  logic lane_last, word_last, out_free, in_ready, accept, word_load, trl_load;
  logic [OUT_WIDTH-1:0] load_data;

  assign lane_last = (lane_q == LANE_LAST);
  assign word_last = (word_idx_q == WORD_LAST);
  // Ready never looks at i_in_valid; the final lane waits for room in the output register.
  assign in_ready  = !i_reset && (state_q == ST_DATA) && (!lane_last || out_free);
  assign accept    = i_in_valid && in_ready;
  assign word_load = accept && lane_last;
  assign trl_load  = (APPEND_TRAILER != 0) && (state_q == ST_TRAILER) && out_free;

  always_comb begin
    word_d = asm_q;
    word_d[lane_q*IN_WIDTH +: IN_WIDTH] = i_in_data;
    csum_d = csum_q + 16'(i_in_data);
    load_data = trl_load ? OUT_WIDTH'(trailer_word(seq_q, csum_q)) : word_d;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_DATA;
      lane_q      <= '0;
      word_idx_q  <= '0;
      csum_q      <= '0;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      asm_q       <= '0;
    end else begin
      if (accept) begin
        asm_q  <= word_d;
        csum_q <= csum_d;
        lane_q <= lane_last ? '0 : lane_q + LW'(1);
        if (lane_last) begin
          word_idx_q <= word_last ? '0 : word_idx_q + WW'(1);
          if (word_last) begin
            if (APPEND_TRAILER != 0) begin
              state_q <= ST_TRAILER;
            end else begin
              csum_q      <= '0;
              seq_q       <= seq_q + 16'd1;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end
          end
        end
      end
      if (trl_load) begin
        csum_q      <= '0;
        seq_q       <= seq_q + 16'd1;
        frame_cnt_q <= frame_cnt_q + 16'd1;
        state_q     <= ST_DATA;
      end
    end
  end

  concat_out_reg #(.W(OUT_WIDTH)) u_out_reg (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .load_i  (word_load || trl_load),
    .data_i  (load_data),
    .first_i (!trl_load && (word_idx_q == '0)),
    .last_i  (trl_load || (word_last && (APPEND_TRAILER == 0))),
    .ready_i (i_out_ready),
    .free_o  (out_free),
    .valid_o (o_out_valid),
    .data_o  (o_out_data),
    .first_o (o_out_first),
    .last_o  (o_out_last)
  );

  assign o_in_ready    = in_ready;
  assign o_frame_count = frame_cnt_q;
endmodule

// File: tb/tb_concat_frame_packer.sv
// Directed + randomised checks of the frame packer: packing, flags, trailer, backpressure, reset.
module tb_concat_frame_packer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, out_ready, sel;
  logic [7:0] in_data;
  logic       iv0, iv1, r0, r1, v0, v1, f0, f1, l0, l1;
  logic [31:0] d0, d1;
  logic [15:0] fc0, fc1;

  // sel steers the shared stimulus to the trailer (u0) or no-trailer (u1) instance.
  assign iv0 = in_valid & ~sel;
  assign iv1 = in_valid & sel;

  concat_frame_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .FRAME_BYTES(288), .APPEND_TRAILER(1)) u0 (
    .i_clock(clk), .i_reset(rst), .i_in_data(in_data), .i_in_valid(iv0), .o_in_ready(r0),
    .o_out_data(d0), .o_out_valid(v0), .o_out_first(f0), .o_out_last(l0),
    .i_out_ready(out_ready), .o_frame_count(fc0));

  concat_frame_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .FRAME_BYTES(288), .APPEND_TRAILER(0)) u1 (
    .i_clock(clk), .i_reset(rst), .i_in_data(in_data), .i_in_valid(iv1), .o_in_ready(r1),
    .o_out_data(d1), .o_out_valid(v1), .o_out_first(f1), .o_out_last(l1),
    .i_out_ready(out_ready), .o_frame_count(fc1));

  logic        m_rdy, m_vld, m_first, m_last;
  logic [31:0] m_data;
  assign m_rdy   = sel ? r1 : r0;
  assign m_vld   = sel ? v1 : v0;
  assign m_first = sel ? f1 : f0;
  assign m_last  = sel ? l1 : l0;
  assign m_data  = sel ? d1 : d0;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [33:0] got_q[$], exp_q[$];   // {first, last, data}
  logic [7:0]  fb[$];
  logic [15:0] m_seq;

  // Output monitor at the falling edge: capture transfers, check hold-while-stalled.
  logic        pv = 1'b0, pr = 1'b1, stall_win = 1'b0;
  logic [33:0] pw = '0;
  int          hold_viol = 0, stall_acc = 0, stall_blk = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr && (!m_vld || {m_first, m_last, m_data} != pw)) hold_viol <= hold_viol + 1;
      if (m_vld && out_ready) got_q.push_back({m_first, m_last, m_data});
      if (stall_win && in_valid && m_vld && m_rdy) stall_acc <= stall_acc + 1;
      if (stall_win && in_valid && !m_rdy) stall_blk <= stall_blk + 1;
    end
    pv <= m_vld && !rst;
    pr <= out_ready;
    pw <= {m_first, m_last, m_data};
  end

  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic set_ramp(input int n);
    fb.delete();
    for (int k = 0; k < n; k++) fb.push_back(8'(k));
  endtask

  // Reference: little-endian packing, first/last flags, {seq, byte sum} trailer.
  task automatic model_frame(input bit trl);
    logic [15:0] s;
    s = '0;
    for (int w = 0; w < 72; w++)
      exp_q.push_back({(w == 0), (w == 71 && !trl), fb[4*w+3], fb[4*w+2], fb[4*w+1], fb[4*w]});
    foreach (fb[i]) s += 16'(fb[i]);
    if (trl) exp_q.push_back({2'b01, m_seq, s});
    m_seq++;
  endtask

  task automatic send_frame(input int gap_pct);
    int t;
    foreach (fb[i]) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = fb[i];
      t = 0;
      @(negedge clk);
      while (!m_rdy) begin
        t++;
        if (t > 5000) begin
          chk("in_ready_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 20000) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = 1'b0; m_seq = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", v0, 0);
    chk("rst_in_ready", r0, 0);
    chk("rst_data", d0, 0);
    chk("rst_first", f0, 0);
    chk("rst_last", l0, 0);
    chk("rst_fcnt", fc0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", r0, 1);
    @(posedge clk); #1;

    // Ramp frame at full rate; word71 at N+1 and trailer at N+2 after the last byte.
    set_ramp(288);
    model_frame(1);
    send_frame(0);
    @(negedge clk);
    chk("lat_word71", {v0, f0, l0, d0}, {3'b100, 32'h1F1E1D1C});
    @(negedge clk);
    chk("lat_trailer", {v0, f0, l0, d0}, {3'b101, 32'h00008170});
    drain("t1");
    chk("t1_w0", got_q[0], {2'b10, 32'h03020100});
    chk("t1_w71", got_q[71], {2'b00, 32'h1F1E1D1C});
    chk("t1_trl", got_q[72], {2'b01, 32'h00008170});
    chk("t1_fcnt", fc0, 1);
    clear_q();

    // Back-to-back second frame: sequence number advances in the trailer.
    model_frame(1);
    send_frame(0);
    drain("t2");
    chk("t2_w0", got_q[0], {2'b10, 32'h03020100});
    chk("t2_trl", got_q[72], {2'b01, 32'h00018170});
    chk("t2_fcnt", fc0, 2);
    clear_q();

    // Ten-cycle output stall mid-frame.
    model_frame(1);
    fork
      send_frame(0);
      begin
        repeat (100) @(posedge clk);
        stall_win = 1'b1;
        rdy_mode  = 2;
        repeat (10) @(posedge clk);
        rdy_mode  = 0;
        stall_win = 1'b0;
      end
    join
    drain("t3");
    chk("t3_bp_acc_le4", stall_acc <= 4, 1);
    chk("t3_bp_blocked", stall_blk > 0, 1);
    chk("t3_hold", hold_viol, 0);
    chk("t3_fcnt", fc0, 3);
    clear_q();

    // Random bytes, random input gaps and output backpressure over 20 frames.
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) begin
      fb.delete();
      for (int k = 0; k < 288; k++) fb.push_back(8'($urandom));
      model_frame(1);
      send_frame(50);
    end
    drain("t4");
    rdy_mode = 0;
    chk("t4_fcnt", fc0, 23);
    clear_q();
    @(posedge clk); #1;

    // Reset after 100 bytes, then a clean frame of 0x01 bytes.
    set_ramp(100);
    send_frame(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_in_ready", r0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", v0, 0);
    chk("t5_rst_fcnt", fc0, 0);
    @(posedge clk); #1;
    clear_q();
    m_seq = '0;
    fb.delete();
    for (int k = 0; k < 288; k++) fb.push_back(8'h01);
    model_frame(1);
    send_frame(0);
    drain("t5");
    chk("t5_w0", got_q[0], {2'b10, 32'h01010101});
    chk("t5_w40", got_q[40], {2'b00, 32'h01010101});
    chk("t5_trl", got_q[72], {2'b01, 32'h00000120});
    chk("t5_fcnt", fc0, 1);
    clear_q();

    // No-trailer instance: last flag rides on word71, nothing follows.
    sel = 1'b1;
    m_seq = '0;
    chk("t6_fcnt0", fc1, 0);
    set_ramp(288);
    model_frame(0);
    send_frame(0);
    drain("t6");
    chk("t6_w0", got_q[0], {2'b10, 32'h03020100});
    chk("t6_w71", got_q[71], {2'b01, 32'h1F1E1D1C});
    chk("t6_fcnt", fc1, 1);
    clear_q();

    chk("hold_stable", hold_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/concat_frame_packer.md
Name: concat_frame_packer

Overview:
- Sits directly downstream of the three-channel concatenator output FIFO.
- Consumes its 8-bit byte stream, which carries 288-byte frames (144 + 12 + 132 bytes).
- Packs bytes little-endian into 32-bit words, flags the first and last word of each frame, and appends one trailer word holding a 16-bit frame sequence number and a 16-bit byte checksum.
- Output feeds the wide-bus transport stage.

Parameters:
- IN_WIDTH, 8: input byte width; must evenly divide OUT_WIDTH.
- OUT_WIDTH, 32: output word width; must be at least 32 when APPEND_TRAILER=1.
- FRAME_BYTES, 288: bytes per frame; must be a multiple of LANES = OUT_WIDTH/IN_WIDTH.
- APPEND_TRAILER, 1: 1 appends the checksum trailer word; 0 omits it.

Ports:
- i_clock  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_in_data  input  IN_WIDTH  byte from the concatenator output FIFO
- i_in_valid  input  1  input byte valid
- o_in_ready  output  1  block accepts the byte this cycle
- o_out_data  output  OUT_WIDTH  packed word or trailer word
- o_out_valid  output  1  output word valid
- o_out_first  output  1  word is the first word of a frame
- o_out_last  output  1  word is the final word of a frame (the trailer when enabled)
- i_out_ready  input  1  downstream accepts the word
- o_frame_count  output  16  frames completed since reset, wraps at 2^16

Behaviour:
- Clock and reset: clock i_clock; reset i_reset, synchronous, active-high.
- Reset values: o_out_valid=0, o_out_first=0, o_out_last=0, o_out_data=0, o_frame_count=0, o_in_ready=0 during the reset cycle.
- Reset state: lane=0, word_idx=0, checksum=0, seq=0, state=ST_DATA.
- Reset mid-frame discards the partial word and the partial frame. The next accepted byte starts frame lane 0 with a clean checksum.
- Handshakes: a transfer occurs on valid & ready on either side. o_in_ready must not depend on i_in_valid. Output data and flags stay stable while o_out_valid=1 and i_out_ready=0.
- Output register: single word plus flags. It is free when o_out_valid=0 or i_out_ready=1 in the current cycle.
- ST_DATA, lane < LANES-1: o_in_ready=1. An accepted byte is written to assembly bits [lane*IN_WIDTH +: IN_WIDTH], and lane increments.
- ST_DATA, lane == LANES-1: o_in_ready = output register free. On accept, the completed word (final byte in the top lane) loads the output register the next cycle. Latency: last byte accepted in cycle N gives o_out_valid in cycle N+1.
- Word flags: o_out_first = (word_idx==0). o_out_last = (word_idx==WORDS-1) & !APPEND_TRAILER.
- Word counting: lane wraps to 0 and word_idx increments. At word_idx==WORDS-1, word_idx wraps to 0.
- End of frame, APPEND_TRAILER=1: go to ST_TRAILER.
- End of frame, APPEND_TRAILER=0: o_frame_count increments and seq increments.
- Checksum: 16-bit modulo-2^16 sum of all accepted bytes of the frame, zero-extended and updated on every accepted byte. The value used for the trailer includes the final byte.
- ST_TRAILER: o_in_ready=0. When the output register is free, load {seq[15:0], checksum} (upper bits zero if OUT_WIDTH>32) with first=0, last=1. In the same cycle, clear checksum, increment seq and o_frame_count, and return to ST_DATA.
- Throughput: one trailer bubble per frame. The earliest trailer is at N+2.
- Simultaneous events: a final-lane accept while the output register is being drained in the same cycle is legal, with no bubble. A byte accept in the same cycle as a checksum clear cannot occur, because o_in_ready=0 in ST_TRAILER.
- i_in_valid gaps of any length are tolerated. The partial word is retained indefinitely.
- Counter widths: lane uses $clog2(LANES) bits; word_idx uses $clog2(WORDS) bits, where WORDS = FRAME_BYTES/LANES. All wraps are explicit compares, not natural overflow.

Decomposition:
- Package concat_pkg:
  - LENGTH1=144, LENGTH2=12, LENGTH3=132, FRAME_BYTES=LENGTH1+LENGTH2+LENGTH3.
  - State enum {ST_DATA, ST_TRAILER}.
  - Trailer field layout constants.
  - Shared with the concatenator so the frame lengths are defined once.
- Sub-module concat_out_reg: one-entry output register with a load/free handshake (data plus first/last flags). Reused for the word path.

Test Plan:
- Full throughput, APPEND_TRAILER=1, i_out_ready=1, input bytes k mod 256 for k=0..287:
  - Expect 73 words; word0 = 0x03020100 with first=1.
  - Expect word71 = 0x1F1E1D1C.
  - Expect trailer = 0x00008170 with last=1; o_frame_count becomes 1.
- Back-to-back frames with the same stimulus: second frame word0 has first=1, trailer = 0x00018170, o_frame_count=2. No byte is dropped or duplicated (scoreboard).
- Backpressure: hold i_out_ready=0 for 10 cycles mid-frame. Expect:
  - o_in_ready drops within 4 accepted bytes.
  - o_out_data and flags stable throughout.
  - Checksum and words unchanged after release.
- Random i_in_valid (50%) and random i_out_ready (50%) over 20 frames: output matches the reference model. Every trailer checksum equals the byte sum mod 65536.
- Reset after 100 bytes of a frame, then send a fresh frame of all bytes 0x01: expect 72 words 0x01010101, word0 first=1, trailer 0x00000120, o_frame_count=1.
- APPEND_TRAILER=0 with the ramp stimulus: 72 words, last=1 on word71 = 0x1F1E1D1C, no trailer, o_frame_count=1.
